// File: rtl/timer_device_if.sv
// Peripheral bus bundle between the CPU and the timer.
// The CPU drives Addr/WE/Din; the timer returns Dout combinationally and drives IRQ.
interface timer_device_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, output WE, output Din, input Dout, input IRQ);
    modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_device.sv
// Memory-mapped 32-bit down-counting timer: one-shot (latched IRQ) or auto-reload (pulsed IRQ).
// Handshake: a bus write is accepted on every posedge where WE=1; reads are combinational, no stall.
module timer_device (
    input  logic              clk,
    input  logic              rst,
    timer_device_if.slave     bus,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic [1:0]  reg_sel;
    logic        enable;
    logic        auto_reload;

    assign reg_sel     = bus.Addr[3:2];
    assign enable      = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= 4'h0;
            preset_q   <= 32'h0;
            count_q    <= 32'h0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    irq_flag_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'h0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus writes come last so a CTRL write overrides the one-shot Enable clear.
        if (bus.WE) begin
            case (reg_sel)
                2'd0:    ctrl_d   = bus.Din[3:0];
                2'd1:    preset_d = bus.Din;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (reg_sel)
            2'd0:    bus.Dout = {28'h0, ctrl_q};
            2'd1:    bus.Dout = preset_q;
            2'd2:    bus.Dout = count_q;
            default: bus.Dout = 32'h0;
        endcase
    end

    assign bus.IRQ     = irq_flag_q & ctrl_q[3];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: per-feature tasks with a queue of expected {IRQ, COUNT} values.
module tb_timer_device;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    timer_device_if bus_if();

    timer_device dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    function automatic logic [31:0] rand_addr(input logic [1:0] idx);
        logic [31:0] a;
        a      = $urandom();
        a[3:2] = idx;
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.WE = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one write; returns 1ns after the edge that accepts it.
    task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
        @(negedge clk);
        bus_if.Addr = rand_addr(idx);
        bus_if.Din  = data;
        bus_if.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] idx, output logic [31:0] d);
        bus_if.Addr = rand_addr(idx);
        #1;
        d = bus_if.Dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            exp_q.push_back(33'h0);
            n_cmp++;
            if ({bus_if.IRQ, d} !== exp_q.pop_front()) begin
                n_err++;
                $display("FAIL reset_read_%0d: irq=%0b dout=%h, want irq=0 dout=0", i, bus_if.IRQ, d);
            end
            step();
        end
        bus_write(2'd2, 32'd5);
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL count_readonly: got %h want 0", d);
        end
        bus_write(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h0000_000F) begin
            n_err++;
            $display("FAIL ctrl_width: got %h want 0000000f", d);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic [32:0] e;
        int n = 5;
        apply_reset();
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            logic [31:0] c;
            if (k < 2 || k - 2 >= n) c = 32'h0;
            else c = 32'(n - (k - 2));
            exp_q.push_back({(k >= n + 2), c});
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            rd(2'd2, d);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus_if.IRQ, d} !== e) begin
                n_err++;
                $display("FAIL oneshot_edge%0d: irq=%0b count=%0d, want irq=%0b count=%0d",
                         k, bus_if.IRQ, d, e[32], e[31:0]);
            end
            if (k == 1 || k == n + 2) begin
                n_cmp++;
                if (dbg_state !== ((k == 1) ? 2'd1 : 2'd3)) begin
                    n_err++;
                    $display("FAIL oneshot_state_edge%0d: got %0d want %0d", k, dbg_state,
                             (k == 1) ? 1 : 3);
                end
            end
        end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h8) begin
            n_err++;
            $display("FAIL oneshot_ctrl_after: got %h want 00000008", d);
        end
        bus_write(2'd0, 32'h9);
        n_cmp++;
        if (bus_if.IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_rearm_edge0: irq=%0b want 1", bus_if.IRQ);
        end
        step();
        n_cmp++;
        if (bus_if.IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_rearm_edge1: irq=%0b want 0", bus_if.IRQ);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        logic [32:0] e;
        apply_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            logic [31:0] c;
            int m;
            m = (k - 2) % 6;
            if (k < 2) c = 32'h0;
            else if (m <= 3) c = 32'(3 - m);
            else c = 32'h0;
            exp_q.push_back({(k >= 2 && m == 3), c});
        end
        for (int k = 1; k <= 22; k++) begin
            step();
            rd(2'd2, d);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus_if.IRQ, d} !== e) begin
                n_err++;
                $display("FAIL reload_edge%0d: irq=%0b count=%0d, want irq=%0b count=%0d",
                         k, bus_if.IRQ, d, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        logic [32:0] e;
        int n;
        n = int'($urandom_range(2, 6));
        apply_reset();
        bus_write(2'd1, 32'(n));
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= n + 4; k++) begin
            logic [31:0] c;
            if (k < 2 || k - 2 >= n) c = 32'h0;
            else c = 32'(n - (k - 2));
            exp_q.push_back({1'b0, c});
        end
        for (int k = 1; k <= n + 4; k++) begin
            step();
            rd(2'd2, d);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus_if.IRQ, d} !== e) begin
                n_err++;
                $display("FAIL mask_edge%0d: irq=%0b count=%0d, want irq=%0b count=%0d",
                         k, bus_if.IRQ, d, e[32], e[31:0]);
            end
        end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL mask_ctrl: got %h want 0", d);
        end
        bus_write(2'd0, 32'h8);
        n_cmp++;
        if (bus_if.IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL mask_unmask: irq=%0b want 1", bus_if.IRQ);
        end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        bit found = 1'b0;
        apply_reset();
        bus_write(2'd1, 32'd100);
        bus_write(2'd0, 32'h1);
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            rd(2'd2, d);
            if (d == 32'd40) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL disable_reach40: count=%0d want 40 within 200 cycles", d);
        end
        bus_write(2'd0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            rd(2'd2, d);
            n_cmp++;
            if ((d !== 32'd39 && d !== 32'd40) || bus_if.IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL disable_freeze_%0d: count=%0d irq=%0b, want count=39|40 irq=0",
                         k, d, bus_if.IRQ);
            end
        end
        bus_write(2'd0, 32'h1);
        step();
        step();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd100) begin
            n_err++;
            $display("FAIL disable_reload: count=%0d want 100", d);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] d;
        apply_reset();
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back({(k == 3), 32'h0});
        end
        for (int k = 1; k <= 3; k++) begin
            logic [32:0] e;
            step();
            rd(2'd2, d);
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus_if.IRQ, d} !== e) begin
                n_err++;
                $display("FAIL preset0_edge%0d: irq=%0b count=%0d, want irq=%0b count=0",
                         k, bus_if.IRQ, d, e[32]);
            end
        end
        apply_reset();
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'h1);
        step();
        step();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL max_load: count=%h want ffffffff", d);
        end
        step();
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL max_dec: count=%h want fffffffe", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        apply_reset();
        bus_write(2'd1, 32'd50);
        bus_write(2'd0, 32'h9);
        for (int k = 0; k < int'($urandom_range(4, 12)); k++) step();
        @(negedge clk);
        rst = 1'b1;
        bus_if.Addr = rand_addr(2'd0);
        bus_if.Din  = 32'hF;
        bus_if.WE   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            n_cmp++;
            if (d !== 32'h0 || bus_if.IRQ !== 1'b0 || dbg_state !== 2'd0) begin
                n_err++;
                $display("FAIL reset_mid_%0d: dout=%h irq=%0b state=%0d, want all 0",
                         i, d, bus_if.IRQ, dbg_state);
            end
        end
    endtask

    initial begin
        bus_if.Addr = 32'h0;
        bus_if.WE   = 1'b0;
        bus_if.Din  = 32'h0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_disable();
        test_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_device.md
# timer_device

Memory-mapped 32-bit down-counting timer on the CPU's peripheral bus that drives one hardware interrupt line into the CP0 `HWInt` inputs. Software programs a preset value and a control word with `sw`, and reads status back with `lw`. The block counts down once per clock and raises `IRQ` on expiry. Mode 0 is one-shot and latches the interrupt. Mode 1 auto-reloads and emits a one-cycle interrupt pulse on each expiry.

## Interface
Parameters:
- none; register width fixed at 32, register map fixed.

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- Addr  in  32  byte address; only Addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped); other bits ignored.
- WE  in  1  bus write strobe, sampled at posedge.
- Din  in  32  write data.
- Dout  out  32  combinational read data selected by Addr[3:2].
- IRQ  out  1  interrupt request to CP0 HWInt, level output.

## Operation
- Registers:
  - CTRL: bits [3:0] stored, bits [31:4] read 0.
    - CTRL[0] = Enable.
    - CTRL[2:1] = Mode; 00 = one-shot, 01 = auto-reload, 1x treated as 01.
    - CTRL[3] = IM, the interrupt mask.
  - PRESET: 32-bit read/write.
  - COUNT: 32-bit, read-only; writes are ignored.
- Reads:
  - Dout = CTRL, PRESET or COUNT per Addr[3:2].
  - Addr[3:2]=3 reads 32'h0.
- Writes (WE=1):
  - Addr[3:2]=0 writes CTRL ← {28'b0, Din[3:0]}.
  - Addr[3:2]=1 writes PRESET ← Din.
  - Writing PRESET does not restart a count in progress; the new value takes effect at the next LOAD.
- Internal flag irq_flag. Output IRQ = irq_flag & CTRL[3], combinational.
- FSM states IDLE, LOAD, CNT, INT; transitions evaluated on pre-edge register values:
  - IDLE:
    - if Enable: irq_flag←0, go to LOAD.
    - else stay in IDLE; COUNT and irq_flag hold.
  - LOAD: COUNT←PRESET, go to CNT.
  - CNT:
    - if !Enable: go to IDLE, COUNT holds.
    - else if COUNT>1: COUNT←COUNT−1.
    - else (COUNT is 0 or 1): COUNT←0, irq_flag←1, go to INT.
  - INT:
    - Mode 0: clear Enable; irq_flag stays 1.
    - Mode 1: irq_flag←0.
    - Either mode: go to IDLE.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as the INT-state Enable clear: the bus write wins, and CTRL takes Din[3:0].
  - Clearing IM masks IRQ immediately but does not clear irq_flag; setting IM again re-exposes a pending mode-0 interrupt.
  - The mode-0 interrupt is acknowledged only by re-enabling the timer (IDLE clears irq_flag) or by reset.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Therefore IRQ=0 and Dout=0 for any Addr.
- Reset asserted mid-count has priority over bus writes and FSM updates.

## Timing
- Take edge t as the edge that writes Enable=1, with PRESET=N.
  - t+1: LOAD.
  - t+2: COUNT=N.
  - COUNT decrements once per subsequent edge.
  - t+N+2: COUNT=0, state=INT, IRQ=1 (if IM=1), for N≥1.
- PRESET=0 behaves as N=1: IRQ after t+3.
- Mode 0:
  - IRQ stays high from t+N+2 until software re-enables the timer.
  - Enable reads 0 from t+N+3.
- Mode 1:
  - IRQ is high for exactly one cycle, between edges t+N+2 and t+N+3.
  - Reload reaches COUNT=N at t+N+5.
  - Interrupt period is N+3 cycles.
- Reads are zero-latency (combinational); a read in the same cycle as a write returns the old value.
- Disabling during CNT:
  - Takes one edge to reach IDLE.
  - COUNT freezes at the value it holds at that edge.
  - Re-enabling reloads from PRESET; there is no resume.

## Test plan
- Reset, then read all four addresses:
  - Dout=0 for each, IRQ=0.
  - Write COUNT=5, read back 0.
  - Write CTRL=32'hFFFF_FFFF, read back 32'h0000_000F.
- Mode 0 one-shot:
  - Stimulus: PRESET=5, then CTRL=32'h9.
  - COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD.
  - IRQ rises 7 edges after the CTRL write and stays high.
  - CTRL reads 32'h8 afterwards.
  - Rewriting CTRL=32'h9 drops IRQ after one edge.
- Mode 1 auto-reload:
  - Stimulus: PRESET=3, CTRL=32'hB.
  - IRQ pulses one cycle wide every 6 cycles, across at least 3 periods.
- Masking:
  - Mode 0 with CTRL=32'h1 (IM=0) expires with IRQ=0.
  - Writing CTRL=32'h8 then shows IRQ=1 from the pending flag.
- Disable mid-count:
  - Stimulus: PRESET=100; at COUNT=40 write CTRL=0.
  - COUNT freezes at 39 or 40, depending on the edge.
  - No IRQ fires.
  - Re-enabling reloads 100.
- Boundary conditions:
  - PRESET=0 gives IRQ 3 edges after enable.
  - PRESET=32'hFFFF_FFFF loads without wrap; COUNT decrements to 32'hFFFF_FFFE.
  - Asserting rst mid-count returns every register, COUNT and IRQ to 0 after one edge.
